id_ex_pipe: RTL

- ID/EX pipeline register directly downstream of the decode-stage control unit.
- Captures that unit's control bundle, register-file read data, immediate and register addresses into the EX stage.
- Detects load-use hazards and drives the control unit's `stall` input.
- Inserts bubbles on stall or flush, latches a sticky CPU-halted flag and counts stall cycles.

---
 rtl/id_ex_pipe_pkg.sv | 22 ++
 rtl/id_ex_pipe_hazard_detect.sv | 25 ++
 rtl/id_ex_pipe.sv | 129 ++++++++++++
 3 files changed

// File: rtl/id_ex_pipe_pkg.sv
// Types and constants shared by the ID/EX pipeline register and its hazard unit.
package id_ex_pipe_pkg;

  localparam logic [1:0] WD3_ALU = 2'b00;
  localparam logic [1:0] WD3_IMM = 2'b01;
  localparam logic [1:0] WD3_MEM = 2'b10;

  typedef struct packed {
    logic       we3;
    logic       we_flags;
    logic       s_mem_in;
    logic       s_addr;
    logic [1:0] s_wd3;
    logic [2:0] op_alu;
    logic       read;
    logic       write;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by the ID instruction.
module hazard_detect #(
  parameter int REG_AW  = 4,
  parameter int R0_ZERO = 1
) (
  input  logic              valid_ex_i,
  input  logic              read_ex_i,
  input  logic              we3_ex_i,
  input  logic [REG_AW-1:0] rd_ex_i,
  input  logic [REG_AW-1:0] rs1_id_i,
  input  logic [REG_AW-1:0] rs2_id_i,
  input  logic              use_rs1_id_i,
  input  logic              use_rs2_id_i,
  output logic              stall_o
);

  logic hit;
  logic r0_masked;

  assign hit       = (use_rs1_id_i && (rs1_id_i == rd_ex_i)) ||
                     (use_rs2_id_i && (rs2_id_i == rd_ex_i));
  assign r0_masked = (R0_ZERO != 0) && (rd_ex_i == '0);
  assign stall_o   = valid_ex_i && read_ex_i && we3_ex_i && hit && !r0_masked;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use stall, bubble insertion, sticky halt and stall counter.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 4,
  parameter int CNT_W   = 16,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3_id,
  input  logic              we_flags_id,
  input  logic              s_mem_in_id,
  input  logic              s_addr_id,
  input  logic [1:0]        s_wd3_id,
  input  logic [2:0]        op_alu_id,
  input  logic              read_id,
  input  logic              write_id,
  input  logic              halted_id,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic [REG_AW-1:0] rd_id,
  input  logic              use_rs1_id,
  input  logic              use_rs2_id,
  input  logic [DATA_W-1:0] rd1_id,
  input  logic [DATA_W-1:0] rd2_id,
  input  logic [DATA_W-1:0] imm_id,
  input  logic              flush_ex,
  output logic              stall,
  output logic              we3_ex,
  output logic              we_flags_ex,
  output logic              s_mem_in_ex,
  output logic              s_addr_ex,
  output logic [1:0]        s_wd3_ex,
  output logic [2:0]        op_alu_ex,
  output logic              read_ex,
  output logic              write_ex,
  output logic [REG_AW-1:0] rd_ex,
  output logic [DATA_W-1:0] rd1_ex,
  output logic [DATA_W-1:0] rd2_ex,
  output logic [DATA_W-1:0] imm_ex,
  output logic              valid_ex,
  output logic              cpu_halted,
  output logic [CNT_W-1:0]  stall_count
);

  ctrl_t             ctrl_id, ctrl_d, ctrl_q;
  logic [REG_AW-1:0] rd_d, rd_q;
  logic [DATA_W-1:0] rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
  logic              valid_d, valid_q;
  logic              halted_d, halted_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              capture;

  assign ctrl_id = '{we3: we3_id, we_flags: we_flags_id, s_mem_in: s_mem_in_id,
                     s_addr: s_addr_id, s_wd3: s_wd3_id, op_alu: op_alu_id,
                     read: read_id, write: write_id, halted: halted_id};

  hazard_detect #(
    .REG_AW (REG_AW),
    .R0_ZERO(R0_ZERO)
  ) u_hazard (
    .valid_ex_i  (valid_q),
    .read_ex_i   (ctrl_q.read),
    .we3_ex_i    (ctrl_q.we3),
    .rd_ex_i     (rd_q),
    .rs1_id_i    (rs1_id),
    .rs2_id_i    (rs2_id),
    .use_rs1_id_i(use_rs1_id),
    .use_rs2_id_i(use_rs2_id),
    .stall_o     (stall)
  );

  // Flush and stall both collapse to a single bubble; flush simply has priority.
  assign capture = !flush_ex && !stall;

  always_comb begin
    ctrl_d  = capture ? ctrl_id : BUBBLE;
    rd_d    = capture ? rd_id   : '0;
    rd1_d   = capture ? rd1_id  : '0;
    rd2_d   = capture ? rd2_id  : '0;
    imm_d   = capture ? imm_id  : '0;
    valid_d = capture;
    // The captured HALT bit is visible in ctrl_q on the capture edge and is folded
    // into the sticky flop on the next edge, so cpu_halted rises with the capture.
    halted_d = halted_q || ctrl_q.halted;
    cnt_d    = (stall && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q   <= BUBBLE;
      rd_q     <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      rd_q     <= rd_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      imm_q    <= imm_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign we3_ex      = ctrl_q.we3;
  assign we_flags_ex = ctrl_q.we_flags;
  assign s_mem_in_ex = ctrl_q.s_mem_in;
  assign s_addr_ex   = ctrl_q.s_addr;
  assign s_wd3_ex    = ctrl_q.s_wd3;
  assign op_alu_ex   = ctrl_q.op_alu;
  assign read_ex     = ctrl_q.read;
  assign write_ex    = ctrl_q.write;
  assign rd_ex       = rd_q;
  assign rd1_ex      = rd1_q;
  assign rd2_ex      = rd2_q;
  assign imm_ex      = imm_q;
  assign valid_ex    = valid_q;
  assign cpu_halted  = halted_q || ctrl_q.halted;
  assign stall_count = cnt_q;

endmodule
